// File: rtl/seq_scan_ctrl.sv
// Word-to-bit sequencer: serialises each accepted word MSB-first through a PAT_W-bit matcher, reports per-word and saturating total match counts.
// Latency: result valid WORD_W+1 clocks after accept (accepting clock included); in_ready low in SHIFT/RESULT, result held until out_ready.
// Build option SEQ_SCAN_OVERLAP_EN: overlapping matches count; otherwise the window restarts after each match.
module seq_scan_ctrl #(
    parameter int                WORD_W  = 8,
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PAT_RST = 4'b1011,
    parameter int                CNT_W   = 4,
    localparam int               OCW     = $clog2(WORD_W+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OCW-1:0]    out_count,
    output logic [CNT_W-1:0]  total,
    output logic              busy,
    output logic              ser_bit
);

    localparam int FW = $clog2(PAT_W+1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PAT_W-1:0]  pattern;
    logic [WORD_W-1:0] sreg;
    logic [PAT_W-1:0]  window;
    logic [FW-1:0]     fill;
    logic [OCW-1:0]    bit_cnt;

    logic [PAT_W:0]    win_ext;
    logic [PAT_W-1:0]  win_nxt;
    logic [FW-1:0]     fill_nxt;
    logic              hit;
    logic              last_bit;

    // Window as it stands after the current bit is shifted in.
    always_comb begin
        win_ext  = {window, sreg[WORD_W-1]};
        win_nxt  = win_ext[PAT_W-1:0];
        fill_nxt = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
        hit      = (state == SHIFT) && (fill_nxt == FW'(PAT_W)) && (win_nxt == pattern);
        last_bit = (bit_cnt == OCW'(WORD_W-1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = RESULT;
            RESULT:  if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == RESULT);
        busy      = (state == SHIFT) || (state == RESULT);
        ser_bit   = (state == SHIFT) ? sreg[WORD_W-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern   <= PAT_RST;
            sreg      <= '0;
            window    <= '0;
            fill      <= '0;
            bit_cnt   <= '0;
            out_count <= '0;
            total     <= '0;
        end else begin
            // A write coinciding with an accept lands before the first shift.
            if (state == IDLE && cfg_we) begin
                pattern <= cfg_pat;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg      <= in_data;
                        window    <= '0;
                        fill      <= '0;
                        bit_cnt   <= '0;
                        out_count <= '0;
                    end
                end
                SHIFT: begin
                    sreg    <= sreg << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (hit) begin
                        out_count <= out_count + 1'b1;
                        if (total != {CNT_W{1'b1}}) begin
                            total <= total + 1'b1;
                        end
                    end
`ifdef SEQ_SCAN_OVERLAP_EN
                    window <= win_nxt;
                    fill   <= fill_nxt;
`else
                    if (hit) begin
                        window <= '0;
                        fill   <= '0;
                    end else begin
                        window <= win_nxt;
                        fill   <= fill_nxt;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: expected results queued at accept, popped and compared when the result appears.
module tb_seq_scan_ctrl;

    localparam int WORD_W = 8;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 4;
    localparam int OCW    = $clog2(WORD_W+1);
    localparam int TOTMAX = (1 << CNT_W) - 1;
`ifdef SEQ_SCAN_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pat;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OCW-1:0]    out_count;
    logic [CNT_W-1:0]  total;
    logic              busy;
    logic              ser_bit;

    seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .PAT_RST(4'b1011), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .total(total), .busy(busy), .ser_bit(ser_bit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int tot;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_total = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_total = 0;
        sb.delete();
    endtask

    // Reference count: slide a PAT_W-wide view over the word, skipping past a hit when overlap is off.
    function automatic int model_count(input logic [WORD_W-1:0] w, input logic [PAT_W-1:0] p);
        int i = 0;
        int c = 0;
        while (i <= WORD_W - PAT_W) begin
            if (w[WORD_W-1-i -: PAT_W] == p) begin
                c++;
                i += OVL ? 1 : PAT_W;
            end else begin
                i++;
            end
        end
        return c;
    endfunction

    function automatic void push_exp(input int cnt);
        exp_t e;
        exp_total = (exp_total + cnt > TOTMAX) ? TOTMAX : exp_total + cnt;
        e.cnt = cnt;
        e.tot = exp_total;
        sb.push_back(e);
    endfunction

    task automatic run_word(input string tag, input logic [WORD_W-1:0] d, input int exp_cnt,
                            input int hold, input bit cfg_mid);
        int   n;
        int   lat;
        exp_t e;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_idle_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        push_exp(exp_cnt);
        step();
        cfg_we   = 1'b0;
        in_valid = (hold > 0);
        in_data  = ~d;
        lat = 1;
        chk({tag, "_ser_bit"}, int'(ser_bit), int'(d[WORD_W-1]));
        chk({tag, "_busy"}, int'(busy), 1);
        if (cfg_mid) begin
            cfg_we  = 1'b1;
            cfg_pat = 4'b0110;
            step();
            cfg_we = 1'b0;
            lat++;
        end
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, lat, WORD_W + 1);
        e = sb.pop_front();
        chk({tag, "_count"}, int'(out_count), e.cnt);
        chk({tag, "_total"}, int'(total), e.tot);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, "_hold_valid"}, int'(out_valid), 1);
            chk({tag, "_hold_count"}, int'(out_count), e.cnt);
            chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drained"}, int'(out_valid), 0);
        chk({tag, "_total_after"}, int'(total), e.tot);
    endtask

    initial begin
        int cyc;
        int last;
        int ov;
        logic [WORD_W-1:0] rw;

        rst = 1'b0; cfg_we = 1'b0; cfg_pat = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset and idle state.
        do_reset();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_total", int'(total), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_ser_bit", int'(ser_bit), 0);

        // Default pattern 1011: overlap difference shows on 1011_0110.
        run_word("w_b6", 8'b1011_0110, OVL ? 2 : 1, 0, 1'b0);

        do_reset();
        run_word("w_bb", 8'b1011_1011, 2, 0, 1'b0);
        chk("w_bb_total2", int'(total), 2);

        // Backpressure with a competing producer.
        run_word("bp", 8'b1011_1011, 2, 5, 1'b0);
        chk("bp_no_accept", int'(busy), 0);

        // Write during SHIFT is dropped; pattern 0110 would give 0 here.
        run_word("cfg_shift", 8'b1011_1011, 2, 0, 1'b1);

        // Write in IDLE takes effect.
        cfg_we = 1'b1; cfg_pat = 4'b0110;
        step();
        cfg_we = 1'b0;
        run_word("cfg_idle", 8'b0110_0110, 2, 0, 1'b0);

        // Write coinciding with accept applies to that word.
        cfg_we = 1'b1; cfg_pat = 4'b1011;
        run_word("cfg_acc", 8'b1011_1011, 2, 0, 1'b0);

        // A few random words against the reference count.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rw = WORD_W'($urandom);
            run_word("rand", rw, model_count(rw, 4'b1011), 0, 1'b0);
        end

        // Streaming saturation run plus throughput.
        do_reset();
        in_data = 8'b1011_1011; in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; last = 0;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            push_exp(2);
            ov = 0;
            while (!out_valid && ov < 50) begin
                step(); cyc++; ov++;
            end
            e = sb.pop_front();
            chk("sat_count", int'(out_count), e.cnt);
            chk("sat_total", int'(total), e.tot);
            if (k > 0) chk("sat_period", cyc - last, WORD_W + 2);
            last = cyc;
            step(); cyc++;
        end
        chk("sat_total_final", int'(total), TOTMAX);

        // Ninth word aborted by reset mid-scan.
        out_ready = 1'b0;
        step(); step(); step();
        chk("abort_busy", int'(busy), 1);
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        exp_total = 0;
        ov = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) ov++;
            step();
        end
        chk("abort_no_valid", ov, 0);
        chk("abort_total", int'(total), 0);
        chk("abort_in_ready", int'(in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Sequencing controller for the serial pattern-detector datapath. It accepts parallel words over a valid/ready handshake and serialises each word MSB-first through an internal programmable PAT_W-bit pattern matcher, one bit per clock. It returns the per-word match count over a second valid/ready handshake and keeps a saturating running total. It sits between a word-oriented producer/consumer and the bit-serial detection logic, and owns pattern configuration.

Parameters:
WORD_W, 8, bits per input word; must be >= PAT_W
PAT_W, 4, pattern length in bits
PAT_RST, 4'b1011, pattern value loaded at reset
CNT_W, 4, width of the running total counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
cfg_we  input  1  pattern write strobe; honoured only in IDLE
cfg_pat  input  PAT_W  new pattern; bit PAT_W-1 is the oldest bit of the window
in_valid  input  1  producer has a word
in_ready  output  1  controller can accept a word
in_data  input  WORD_W  word to scan, MSB shifted first
out_valid  output  1  result available
out_ready  input  1  consumer takes the result
out_count  output  $clog2(WORD_W+1)  matches found in the last word
total  output  CNT_W  saturating count of all matches since reset
busy  output  1  high in SHIFT or RESULT
ser_bit  output  1  bit currently presented to the matcher (debug)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, pattern=PAT_RST, window and bit-fill counter cleared, out_valid=0, out_count=0, total=0, ser_bit=0. Reset mid-word aborts the scan with no result.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data, clear the window, clear the fill count and out_count, and go to SHIFT.
  - SHIFT: each cycle, shift the next bit (MSB first) into the window; ser_bit shows that bit. After WORD_W cycles, go to RESULT.
  - RESULT: out_valid=1 and out_count is held stable. On out_ready, go to IDLE the next cycle.
- Match evaluation:
  - A match is the window (including the bit just shifted) equal to the pattern, with the fill count >= PAT_W.
  - On a match, out_count and total each increment by one in the same cycle.
  - total saturates at 2^CNT_W-1 and never wraps.
- The window does not carry across words; each word is scanned independently.
- Latency: out_valid rises exactly WORD_W+1 clocks after the accepting edge. Throughput is one word per WORD_W+2 clocks when out_ready is held high.
- in_ready=0 in SHIFT and RESULT. in_valid in those states is ignored and the producer holds its data.
- cfg_we:
  - In IDLE, the pattern updates at the next edge.
  - If cfg_we coincides with a word accept, the new pattern applies to that word.
  - Outside IDLE, cfg_we is dropped silently.
- out_valid stays asserted until out_ready; outputs are stable while out_valid=1 and out_ready=0.

Optional Feature:
Macro SEQ_SCAN_OVERLAP_EN.
- Defined: overlapping matches count; the window is kept after a match.
- Undefined: after a match, the window and fill count clear, so the next match needs PAT_W fresh bits (non-overlapping).

Test Plan:
- Reset then idle: rst high 2 cycles -> in_ready=1, out_valid=0, total=0, busy=0. Default pattern 1011 is active.
- Word 8'b1011_0110, pattern 1011:
  - -> out_count=2 with SEQ_SCAN_OVERLAP_EN, 1 without.
  - out_valid rises 9 clocks after accept.
- Word 8'b1011_1011 -> out_count=2 in both builds. total=2 after the result.
- Backpressure: hold out_ready=0 for 5 cycles in RESULT while in_valid=1 -> out_count stays stable, in_ready stays 0, and no second word is accepted.
- Config:
  - cfg_we with cfg_pat=4'b0110 during SHIFT -> ignored, pattern stays 1011.
  - The same write in IDLE, then word 8'b0110_0110 -> out_count=2 (overlap build) or 2 (non-overlap build).
- Saturation: 8 consecutive words 8'b1011_1011 with CNT_W=4 -> total=15 after the 8th word, not 0. Asserting rst mid-SHIFT on a 9th word -> no out_valid, total=0.
